// File: rtl/sync_fifo_param.sv
// sync_fifo_param: single-clock parametrised FIFO with occupancy and almost flags.
// Define SYNC_FIFO_ERR_FLAGS_EN to add sticky OVERFLOW/UNDERFLOW with CLR_ERR.
module sync_fifo_param #(
    parameter int DATA_WIDTH = 8,
    parameter int ADDR_WIDTH = 3,
    parameter int AF_MARGIN  = 1,
    parameter int AE_MARGIN  = 1,
    parameter int SHOW_AHEAD = 1
) (
    input  logic                  CLK,
    input  logic                  RST,
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    input  logic                  CLR_ERR,
    output logic                  OVERFLOW,
    output logic                  UNDERFLOW,
`endif
    input  logic                  W_INC,
    input  logic [DATA_WIDTH-1:0] WR_DATA,
    input  logic                  R_INC,
    output logic [DATA_WIDTH-1:0] RD_DATA,
    output logic                  FULL,
    output logic                  EMPTY,
    output logic                  ALMOST_FULL,
    output logic                  ALMOST_EMPTY,
    output logic [ADDR_WIDTH:0]   COUNT
);

    localparam int DEPTH    = 1 << ADDR_WIDTH;
    localparam int AF_LEVEL = DEPTH - AF_MARGIN;

    logic [DATA_WIDTH-1:0] mem [DEPTH];
    logic [ADDR_WIDTH:0]   wr_ptr;
    logic [ADDR_WIDTH:0]   rd_ptr;
    logic [ADDR_WIDTH:0]   count;
    logic [ADDR_WIDTH-1:0] wr_addr;
    logic [ADDR_WIDTH-1:0] rd_addr;
    logic                  full;
    logic                  empty;
    logic                  wr_acc;
    logic                  rd_acc;
    logic [DATA_WIDTH-1:0] rd_q;

    assign wr_addr = wr_ptr[ADDR_WIDTH-1:0];
    assign rd_addr = rd_ptr[ADDR_WIDTH-1:0];

    // Pointer MSB tells a full lap from an empty one at equal addresses.
    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[ADDR_WIDTH] != rd_ptr[ADDR_WIDTH]) &&
                   (wr_addr == rd_addr);

    assign wr_acc = W_INC & ~full;
    assign rd_acc = R_INC & ~empty;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (wr_acc) wr_ptr <= wr_ptr + 1'b1;
            if (rd_acc) rd_ptr <= rd_ptr + 1'b1;
            unique case ({wr_acc, rd_acc})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_ff @(posedge CLK) begin
        if (RST && wr_acc) mem[wr_addr] <= WR_DATA;
    end

    generate
        if (SHOW_AHEAD != 0) begin : g_show_ahead
            // Remember the head so the bus holds its value once drained.
            always_ff @(posedge CLK) begin
                if (!RST)       rd_q <= '0;
                else if (!empty) rd_q <= mem[rd_addr];
            end
            assign RD_DATA = empty ? rd_q : mem[rd_addr];
        end else begin : g_registered
            always_ff @(posedge CLK) begin
                if (!RST)        rd_q <= '0;
                else if (rd_acc) rd_q <= mem[rd_addr];
            end
            assign RD_DATA = rd_q;
        end
    endgenerate

    assign FULL         = full;
    assign EMPTY        = empty;
    assign COUNT        = count;
    assign ALMOST_FULL  = (int'(count) >= AF_LEVEL);
    assign ALMOST_EMPTY = (int'(count) <= AE_MARGIN);

`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic ovf_q;
    logic unf_q;

    always_ff @(posedge CLK) begin
        if (!RST) begin
            ovf_q <= 1'b0;
            unf_q <= 1'b0;
        end else begin
            if (W_INC && full)   ovf_q <= 1'b1;
            else if (CLR_ERR)    ovf_q <= 1'b0;
            if (R_INC && empty)  unf_q <= 1'b1;
            else if (CLR_ERR)    unf_q <= 1'b0;
        end
    end

    assign OVERFLOW  = ovf_q;
    assign UNDERFLOW = unf_q;
`endif

endmodule

// File: tb/tb_sync_fifo_param.sv
// tb_sync_fifo_param: checks show-ahead and registered FIFOs against a queue model.
// Error-flag checks are active when SYNC_FIFO_ERR_FLAGS_EN is defined.
module tb_sync_fifo_param;

    localparam int DEPTH = 8;

    logic       clk;
    logic       rst_n;
    logic       w_inc;
    logic [7:0] wr_data;
    logic       r_inc;
    logic       clr_err;

    logic [7:0] rd_a, rd_b;
    logic       full_a, empty_a, af_a, ae_a;
    logic       full_b, empty_b, af_b, ae_b;
    logic [3:0] count_a, count_b;
`ifdef SYNC_FIFO_ERR_FLAGS_EN
    logic       ovf_a, unf_a, ovf_b, unf_b;
`endif

    int n_checks = 0;
    int n_err    = 0;

    byte unsigned q[$];
    logic [7:0]   last_sa;
    logic [7:0]   last_reg;
    logic         m_ovf;
    logic         m_unf;

    sync_fifo_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_MARGIN(1),
        .AE_MARGIN(1), .SHOW_AHEAD(1)
    ) dut_a (
        .CLK(clk), .RST(rst_n),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .CLR_ERR(clr_err), .OVERFLOW(ovf_a), .UNDERFLOW(unf_a),
`endif
        .W_INC(w_inc), .WR_DATA(wr_data), .R_INC(r_inc),
        .RD_DATA(rd_a), .FULL(full_a), .EMPTY(empty_a),
        .ALMOST_FULL(af_a), .ALMOST_EMPTY(ae_a), .COUNT(count_a)
    );

    sync_fifo_param #(
        .DATA_WIDTH(8), .ADDR_WIDTH(3), .AF_MARGIN(1),
        .AE_MARGIN(1), .SHOW_AHEAD(0)
    ) dut_b (
        .CLK(clk), .RST(rst_n),
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        .CLR_ERR(clr_err), .OVERFLOW(ovf_b), .UNDERFLOW(unf_b),
`endif
        .W_INC(w_inc), .WR_DATA(wr_data), .R_INC(r_inc),
        .RD_DATA(rd_b), .FULL(full_b), .EMPTY(empty_b),
        .ALMOST_FULL(af_b), .ALMOST_EMPTY(ae_b), .COUNT(count_b)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h at %0t", nm, act, exp, $time);
        end
    endtask

    // Reference: FIFO as a queue; flags follow from its size.
    task automatic model(input logic rn, input logic w, input logic [7:0] d,
                         input logic r, input logic c);
        int  n;
        bit  f;
        bit  e;
        n = q.size();
        f = (n == DEPTH);
        e = (n == 0);
        if (!rn) begin
            q.delete();
            last_sa  = 8'h00;
            last_reg = 8'h00;
            m_ovf    = 1'b0;
            m_unf    = 1'b0;
        end else begin
            if (w && f)      m_ovf = 1'b1;
            else if (c)      m_ovf = 1'b0;
            if (r && e)      m_unf = 1'b1;
            else if (c)      m_unf = 1'b0;
            if (!e)          last_sa = q[0];
            if (r && !e)     last_reg = q.pop_front();
            if (w && !f)     q.push_back(d);
        end
    endtask

    task automatic check_all();
        int         n;
        logic [7:0] exp_sa;
        n = q.size();
        exp_sa = (n != 0) ? q[0] : last_sa;
        chk("count_a", count_a, n);
        chk("full_a", full_a, n == DEPTH);
        chk("empty_a", empty_a, n == 0);
        chk("af_a", af_a, n >= DEPTH - 1);
        chk("ae_a", ae_a, n <= 1);
        chk("rd_a", rd_a, exp_sa);
        chk("count_b", count_b, n);
        chk("full_b", full_b, n == DEPTH);
        chk("empty_b", empty_b, n == 0);
        chk("af_b", af_b, n >= DEPTH - 1);
        chk("ae_b", ae_b, n <= 1);
        chk("rd_b", rd_b, last_reg);
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("ovf_a", ovf_a, m_ovf);
        chk("unf_a", unf_a, m_unf);
        chk("ovf_b", ovf_b, m_ovf);
        chk("unf_b", unf_b, m_unf);
`endif
    endtask

    task automatic step(input logic rn, input logic w, input logic [7:0] d,
                        input logic r, input logic c);
        rst_n   = rn;
        w_inc   = w;
        wr_data = d;
        r_inc   = r;
        clr_err = c;
        @(posedge clk);
        model(rn, w, d, r, c);
        #1;
        check_all();
    endtask

    typedef struct {
        logic       rn;
        logic       w;
        logic [7:0] d;
        logic       r;
        int         cnt;
        logic       af;
        logic       full;
        logic       empty;
        logic [7:0] rd_sa;
        logic [7:0] rd_reg;
    } vec_t;

    vec_t tbl[19];

    initial begin
        rst_n = 1'b0; w_inc = 1'b0; wr_data = 8'h00;
        r_inc = 1'b0; clr_err = 1'b0;
        last_sa = 8'h00; last_reg = 8'h00; m_ovf = 1'b0; m_unf = 1'b0;

        // Reset, fill A0..A7, overfill, drain, underflow.
        tbl[0] = '{1'b0, 1'b0, 8'h00, 1'b0, 0, 1'b0, 1'b0, 1'b1, 8'h00, 8'h00};
        for (int i = 1; i <= 8; i++)
            tbl[i] = '{1'b1, 1'b1, 8'(8'hA0 + i - 1), 1'b0, i,
                       i >= 7, i == 8, 1'b0, 8'hA0, 8'h00};
        tbl[9] = '{1'b1, 1'b1, 8'hFF, 1'b0, 8, 1'b1, 1'b1, 1'b0, 8'hA0, 8'h00};
        for (int k = 1; k <= 8; k++)
            tbl[9+k] = '{1'b1, 1'b0, 8'h00, 1'b1, 8 - k, (8 - k) >= 7,
                         1'b0, k == 8, (k == 8) ? 8'hA7 : 8'(8'hA0 + k),
                         8'(8'hA0 + k - 1)};
        tbl[18] = '{1'b1, 1'b0, 8'h00, 1'b1, 0, 1'b0, 1'b0, 1'b1, 8'hA7, 8'hA7};

        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 19; i++) begin
            step(tbl[i].rn, tbl[i].w, tbl[i].d, tbl[i].r, 1'b0);
            chk("tbl_count", count_a, tbl[i].cnt);
            chk("tbl_af", af_a, tbl[i].af);
            chk("tbl_full", full_a, tbl[i].full);
            chk("tbl_empty", empty_a, tbl[i].empty);
            chk("tbl_rd_sa", rd_a, tbl[i].rd_sa);
            chk("tbl_rd_reg", rd_b, tbl[i].rd_reg);
            if (i == 0) chk("tbl_ae_reset", ae_a, 1'b1);
        end
`ifdef SYNC_FIFO_ERR_FLAGS_EN
        chk("sticky_ovf", ovf_a, 1'b1);
        chk("sticky_unf", unf_a, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
        chk("clr_ovf", ovf_a, 1'b0);
        chk("clr_unf", unf_a, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b1);
        chk("set_beats_clr", unf_a, 1'b1);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b1);
`endif

        // Full with simultaneous write and read: write dropped.
        for (int i = 0; i < 8; i++)
            step(1'b1, 1'b1, 8'(8'hB0 + i), 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'hEE, 1'b1, 1'b0);
        chk("full_rw_count", count_a, 7);
        for (int i = 1; i < 8; i++) begin
            chk("full_rw_data", rd_a, 8'(8'hB0 + i));
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        end
        chk("full_rw_empty", empty_a, 1'b1);

        // Empty with simultaneous write and read: read ignored.
        step(1'b1, 1'b1, 8'h5A, 1'b1, 1'b0);
        chk("empty_rw_count", count_a, 1);
        chk("empty_rw_head", rd_a, 8'h5A);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("empty_rw_pop", rd_b, 8'h5A);

        // Wrap-around with occupancy kept within 2..5.
        for (int i = 0; i < 3; i++)
            step(1'b1, 1'b1, 8'($urandom), 1'b0, 1'b0);
        for (int i = 0; i < 40; i++) begin
            logic w, r;
            w = (q.size() < 5) && ($urandom_range(0, 3) != 0);
            r = (q.size() > 2) && ($urandom_range(0, 3) != 0);
            step(1'b1, w, 8'($urandom), r, 1'b0);
            chk("wrap_max5", count_a <= 4'd5, 1'b1);
        end
        while (q.size() != 0)
            step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);

        // Registered latency, then reset mid-operation.
        step(1'b1, 1'b1, 8'h11, 1'b0, 1'b0);
        step(1'b1, 1'b1, 8'h22, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b1, 1'b0);
        chk("reg_latency", rd_b, 8'h11);
        step(1'b0, 1'b1, 8'h33, 1'b0, 1'b0);
        step(1'b1, 1'b0, 8'h00, 1'b0, 1'b0);
        chk("midrst_count", count_b, 0);
        chk("midrst_empty", empty_b, 1'b1);
        chk("midrst_rd", rd_b, 8'h00);

        // Random stress, alternating fill-biased and drain-biased phases.
        for (int ph = 0; ph < 4; ph++) begin
            int pw;
            pw = (ph % 2 == 0) ? 75 : 25;
            for (int i = 0; i < 100; i++) begin
                logic rn, w, r, c;
                rn = ($urandom_range(0, 59) != 0);
                w  = ($urandom_range(0, 99) < pw);
                r  = ($urandom_range(0, 99) < 100 - pw);
                c  = ($urandom_range(0, 9) == 0);
                step(rn, w, 8'($urandom), r, c);
            end
        end

        $display("Result: errors=%0d of %0d checks", n_err, n_checks);
        $finish;
    end

endmodule

// File: doc/sync_fifo_param.md
Name: sync_fifo_param

Overview:
Single-clock parametrised FIFO, next generation of the team's FIFO family, used for same-domain buffering between producer and consumer blocks.
- Generalises the fixed 8-bit FIFO in data width and depth.
- Adds occupancy count, programmable almost-full/almost-empty flags and a selectable read mode (show-ahead or registered).
- Write/read handshake is W_INC/R_INC against FULL/EMPTY, same as the existing FIFO.

Parameters:
DATA_WIDTH, 8, width of WR_DATA/RD_DATA.
ADDR_WIDTH, 3, log2(depth); DEPTH = 2**ADDR_WIDTH (default 8).
AF_MARGIN, 1, ALMOST_FULL asserts when COUNT >= DEPTH-AF_MARGIN; legal range 0..DEPTH-1.
AE_MARGIN, 1, ALMOST_EMPTY asserts when COUNT <= AE_MARGIN; legal range 0..DEPTH-1.
SHOW_AHEAD, 1, 1 = head word visible on RD_DATA while EMPTY=0; 0 = RD_DATA registered one cycle after accepted R_INC.

Ports:
CLK  in  1  clock, all logic on rising edge.
RST  in  1  synchronous active-low reset.
W_INC  in  1  write request; accepted when FULL=0.
WR_DATA  in  DATA_WIDTH  write data, sampled with W_INC.
R_INC  in  1  read request (pop); accepted when EMPTY=0.
RD_DATA  out  DATA_WIDTH  read data (timing per SHOW_AHEAD).
FULL  out  1  COUNT == DEPTH.
EMPTY  out  1  COUNT == 0.
ALMOST_FULL  out  1  COUNT >= DEPTH-AF_MARGIN.
ALMOST_EMPTY  out  1  COUNT <= AE_MARGIN.
COUNT  out  ADDR_WIDTH+1  current occupancy, 0..DEPTH.

Behaviour:
- Reset (RST=0 at rising edge):
  - Pointers and COUNT -> 0.
  - Outputs: EMPTY=1, FULL=0, ALMOST_EMPTY=1, ALMOST_FULL=(AF_MARGIN>=DEPTH ? 1 : 0), RD_DATA=0.
  - Memory contents are not cleared.
  - Reset mid-operation discards all stored data; requests in the reset cycle are ignored.
- Pointers: wr_ptr/rd_ptr are ADDR_WIDTH+1 bits wide, increment by 1 on each accepted operation and wrap modulo 2*DEPTH. Memory is addressed by the low ADDR_WIDTH bits.
- Accept rules:
  - wr_acc = W_INC & ~FULL.
  - rd_acc = R_INC & ~EMPTY.
  - Both are evaluated on the flags registered at the start of the cycle.
- COUNT update per cycle:
  - +1 if wr_acc only.
  - -1 if rd_acc only.
  - Unchanged if both or neither.
  - COUNT is a register; all flags decode from registered state only (no combinational path from W_INC/R_INC to any flag).
- Flag latency: a write into an empty FIFO clears EMPTY at the next edge. The write making COUNT=DEPTH sets FULL at that edge.
- Simultaneous events:
  - FULL & W_INC & R_INC: the read is accepted, the write is dropped, COUNT becomes DEPTH-1.
  - EMPTY & W_INC & R_INC: the write is accepted, the read is ignored, COUNT becomes 1.
  - Otherwise, simultaneous write and read are both accepted and COUNT holds.
- Rejected requests: write while FULL and read while EMPTY have no effect on memory, pointers, COUNT or RD_DATA.
- SHOW_AHEAD=1:
  - RD_DATA = mem[rd_ptr] whenever EMPTY=0; the consumer samples RD_DATA before/with R_INC.
  - After a pop, RD_DATA shows the next word in the same cycle the pointer advances.
  - While EMPTY=1, RD_DATA holds its last value (0 after reset).
- SHOW_AHEAD=0: on rd_acc, RD_DATA <= mem[rd_ptr] at that edge (one-cycle latency). Otherwise RD_DATA holds.
- Read-during-write to the same address cannot occur, because the full/empty rules forbid it.

Optional Feature:
Macro SYNC_FIFO_ERR_FLAGS_EN.
- When defined:
  - Adds input CLR_ERR (1 bit) and outputs OVERFLOW and UNDERFLOW (1 bit each).
  - OVERFLOW is set sticky by W_INC while FULL, including the dropped write in the full simultaneous case.
  - UNDERFLOW is set sticky by R_INC while EMPTY, including the ignored read in the empty simultaneous case.
  - Both clear to 0 on reset or CLR_ERR=1.
  - Set has priority over CLR_ERR in the same cycle.
- When undefined: these ports and registers do not exist; all other behaviour is identical.

Test Plan:
- Reset, idle -> EMPTY=1, FULL=0, COUNT=0, ALMOST_EMPTY=1, RD_DATA=0.
- DEPTH=8 (ADDR_WIDTH=3, DATA_WIDTH=8), AF_MARGIN=1: write 8 words 0xA0..0xA7 on consecutive cycles.
  - ALMOST_FULL rises at the edge after the 7th write (COUNT=7).
  - FULL rises after the 8th write.
  - A 9th write of 0xFF is dropped; COUNT stays 8; OVERFLOW=1 with the macro defined.
- From full, SHOW_AHEAD=1: pop 8 times -> RD_DATA sequence 0xA0..0xA7, sampled before each R_INC.
  - EMPTY rises after the 8th pop.
  - An extra R_INC leaves COUNT=0 and sets UNDERFLOW.
- Wrap-around: 20 interleaved write/read pairs with random data, COUNT held between 2 and 5 -> read order matches write order exactly across pointer wraps; COUNT never exceeds 5.
- Simultaneous events:
  - At COUNT=8 assert W_INC=R_INC=1 -> COUNT=7 and the written word is absent from later reads.
  - At COUNT=0 assert W_INC=R_INC=1 with 0x5A -> COUNT=1 and the next pop returns 0x5A.
- SHOW_AHEAD=0, mid-operation reset:
  - Write 0x11, 0x22, then pop -> RD_DATA=0x11 one cycle after the R_INC edge.
  - Assert RST=0 for one cycle with W_INC=1 -> COUNT=0 and EMPTY=1 after release; the write is ignored.
